// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared widths, op codes and FSM state type for the delay-line effect controller
package fx_pkg;

    localparam int FX_ADDR_W = 10;
    localparam int FX_DATA_W = 16;

    localparam logic OP_ECHO   = 1'b0;
    localparam logic OP_PHASER = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WT   = 2'd2,
        WR   = 2'd3
    } fx_state_t;

endpackage

// File: rtl/fx_combine.sv
// rtl/fx_combine.sv - combinational saturating echo add / floored phaser subtract
module fx_combine
    import fx_pkg::*;
#(
    parameter int DATA_W = FX_DATA_W
) (
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] del_i,
    input  logic              op_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] res_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // One extra bit: carry flags echo overflow, borrow flags phaser underflow
    always_comb begin
        sum   = {1'b0, in_i} + {1'b0, del_i};
        diff  = {1'b0, in_i} - {1'b0, del_i};
        res_o = in_i;
        if (en_i) begin
            if (op_i == OP_PHASER) begin
                res_o = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
            end else begin
                res_o = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fx_delay_ctrl.sv
// rtl/fx_delay_ctrl.sv - per-sample sequencer: read delayed sample, combine, write input into circular line
module fx_delay_ctrl
    import fx_pkg::*;
#(
    parameter int ADDR_W = FX_ADDR_W,
    parameter int DATA_W = FX_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_audio,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              op,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_audio,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    fx_state_t         state_q,     state_d;
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0] fill_q,      fill_d;
    logic [DATA_W-1:0] in_q,        in_d;
    logic [ADDR_W-1:0] dly_q,       dly_d;
    logic              op_q,        op_d;
    logic              en_q,        en_d;
    logic [DATA_W-1:0] del_q,       del_d;
    logic [DATA_W-1:0] out_audio_q, out_audio_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              overrun_q,   overrun_d;

    logic [DATA_W-1:0] eff_del;
    logic [DATA_W-1:0] comb_res;

    // Slots not yet written since reset (or a zero delay) contribute silence
    assign eff_del = ((dly_q == '0) || (dly_q > fill_q)) ? '0 : del_q;

    fx_combine #(
        .DATA_W (DATA_W)
    ) u_combine (
        .in_i  (in_q),
        .del_i (eff_del),
        .op_i  (op_q),
        .en_i  (en_q),
        .res_o (comb_res)
    );

    // RAM-side outputs are registered, so each is set up on the transition into its state
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        in_d        = in_q;
        dly_d       = dly_q;
        op_d        = op_q;
        en_d        = en_q;
        del_d       = del_q;
        out_audio_d = out_audio_q;
        out_valid_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        overrun_d   = overrun_q | (in_valid && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_d       = in_audio;
                    dly_d      = delay_len;
                    op_d       = op;
                    en_d       = en;
                    mem_addr_d = wr_ptr_q - delay_len;
                    state_d    = RD;
                end
            end
            RD: begin
                state_d = WT;
            end
            WT: begin
                del_d       = mem_rdata;
                mem_addr_d  = wr_ptr_q;
                mem_we_d    = 1'b1;
                mem_wdata_d = in_q;
                state_d     = WR;
            end
            WR: begin
                out_audio_d = comb_res;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            in_q        <= '0;
            dly_q       <= '0;
            op_q        <= OP_ECHO;
            en_q        <= 1'b0;
            del_q       <= '0;
            out_audio_q <= '0;
            out_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            in_q        <= in_d;
            dly_q       <= dly_d;
            op_q        <= op_d;
            en_q        <= en_d;
            del_q       <= del_d;
            out_audio_q <= out_audio_d;
            out_valid_q <= out_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign out_audio = out_audio_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule
